// File: rtl/pi_shuffle_pipe.sv
// rtl/pi_shuffle_pipe.sv - registered transpose/rotate permutation of one NX*NY message frame
// One valid/ready stage; mode and shift are captured together with the frame they apply to.
module pi_shuffle_pipe #(
    parameter int DATA_WIDTH = 6,
    parameter int NX         = 6,
    parameter int NY         = 6,
    parameter int CNT_WIDTH  = 16,
    localparam int N         = NX * NY,
    localparam int SW        = $clog2(((NX > NY) ? NX : NY) + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH*N-1:0] data_in,
    input  logic [1:0]              mode,
    input  logic [SW-1:0]           shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH*N-1:0] data_out,
    output logic [CNT_WIDTH-1:0]    frame_cnt
);

    logic [DATA_WIDTH*N-1:0] t_stage;
    logic [DATA_WIDTH*N-1:0] perm;
    logic [SW-1:0]           s_col;
    logic [SW-1:0]           s_row;
    int                      src;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH*N-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    accept;
    logic                    deliver;

    // Group size is NY after transpose and NX otherwise, so both reductions are kept.
    assign s_col = SW'(shift % NY);
    assign s_row = SW'(shift % NX);

    always_comb begin
        t_stage = '0;
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                if (mode[0]) begin
                    t_stage[(x*NY + y)*DATA_WIDTH +: DATA_WIDTH] = data_in[(y*NX + x)*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    t_stage[(y*NX + x)*DATA_WIDTH +: DATA_WIDTH] = data_in[(y*NX + x)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        perm = t_stage;
        src  = 0;
        if (mode[1]) begin
            if (mode[0]) begin
                for (int g = 0; g < NX; g++) begin
                    for (int j = 0; j < NY; j++) begin
                        src = j + int'(s_col);
                        if (src >= NY) src = src - NY;
                        perm[(g*NY + j)*DATA_WIDTH +: DATA_WIDTH] = t_stage[(g*NY + src)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else begin
                for (int g = 0; g < NY; g++) begin
                    for (int j = 0; j < NX; j++) begin
                        src = j + int'(s_row);
                        if (src >= NX) src = src - NX;
                        perm[(g*NX + j)*DATA_WIDTH +: DATA_WIDTH] = t_stage[(g*NX + src)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        cnt_d       = cnt_q + {{(CNT_WIDTH-1){1'b0}}, deliver};
        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = perm;
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign frame_cnt = cnt_q;

endmodule
